shift_result_writeback: RTL and testbench

- Downstream stage of the 64-bit shifter in the execution cluster.
- Captures each shifter result strobe into a small FIFO: 64-bit data, destination tag, operand size and flags.
- Presents queued results in order to the register-file write port through a WE/GNT handshake, and updates architectural flags at writeback.
- The shifter cannot stall, so the block raises STALL early enough to absorb ops already in flight.

---
 rtl/shift_wb_pkg.sv | 26 ++
 rtl/shift_wb_fifo.sv | 68 ++++++
 rtl/shift_result_writeback.sv | 91 +++++++++
 tb/tb_shift_result_writeback.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_wb_pkg.sv
// Shared types and encodings for the shifter result writeback stage.
// Entry layout, flag bit positions and operand size codes.
package shift_wb_pkg;

    localparam int DST_W = 4;

    localparam int FL_SIGN = 3;
    localparam int FL_ZERO = 2;
    localparam int FL_OVR  = 1;
    localparam int FL_COUT = 0;

    localparam logic [1:0] SZ_8  = 2'b00;
    localparam logic [1:0] SZ_16 = 2'b01;
    localparam logic [1:0] SZ_32 = 2'b10;
    localparam logic [1:0] SZ_64 = 2'b11;

    typedef struct packed {
        logic [63:0]      data;
        logic [DST_W-1:0] dst;
        logic [1:0]       size;
        logic [3:0]       flags;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/shift_wb_fifo.sv
// Generic FIFO with a registered head entry and valid flag.
// A push into an empty (or emptying) queue bypasses into the head register.
module shift_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   push,
    input  logic                   pop_req,
    input  logic [W-1:0]           din,
    output logic                   we,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_nxt,
    output logic                   push_ok,
    output logic                   pop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rptr_nxt;
    logic [W-1:0]  head_nxt;
    logic          full;

    assign full     = (count == CW'(DEPTH));
    assign pop      = we & pop_req;
    assign push_ok  = push & (~full | pop);
    assign rptr_nxt = rptr + AW'(pop);

    always_comb begin
        count_nxt = count + CW'(push_ok) - CW'(pop);
        head_nxt  = mem[rptr_nxt];
        // Pushed entry lands exactly where the next head is read from
        if (push_ok && (rptr_nxt == wptr)) begin
            head_nxt = din;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            we    <= 1'b0;
            head  <= '0;
        end else begin
            wptr  <= wptr + AW'(push_ok);
            rptr  <= rptr_nxt;
            count <= count_nxt;
            we    <= (count_nxt != '0);
            if (count_nxt != '0) begin
                head <= head_nxt;
            end
        end
    end

endmodule

// File: rtl/shift_result_writeback.sv
// Shifter result writeback: queues results, drives the register-file port,
// updates architectural flags at retire and throttles issue via STALL.
module shift_result_writeback
    import shift_wb_pkg::*;
#(
    parameter int DSTWidth = DST_W,
    parameter int DEPTH    = 8,
    parameter int SKID     = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   RDY,
    input  logic [63:0]            R,
    input  logic [DSTWidth-1:0]    DST,
    input  logic [1:0]             SR,
    input  logic                   OVR,
    input  logic                   ZERO,
    input  logic                   COUT,
    input  logic                   SIGN,
    output logic                   STALL,
    output logic                   WE,
    input  logic                   GNT,
    output logic [63:0]            WDATA,
    output logic [DSTWidth-1:0]    WDST,
    output logic [1:0]             WSIZE,
    output logic [3:0]             FLAGS,
    output logic                   FLAGS_WE,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OFLOW
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t     din_e;
    wb_entry_t     head_e;
    logic [CW-1:0] count_nxt;
    logic          push_ok;
    logic          pop;

    always_comb begin
        din_e = '0;
        din_e.data = R;
        din_e.dst  = DST;
        din_e.size = SR;
        din_e.flags[FL_SIGN] = SIGN;
        din_e.flags[FL_ZERO] = ZERO;
        din_e.flags[FL_OVR]  = OVR;
        din_e.flags[FL_COUT] = COUT;
    end

    shift_wb_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (RDY),
        .pop_req   (GNT),
        .din       (din_e),
        .we        (WE),
        .head      (head_e),
        .count     (COUNT),
        .count_nxt (count_nxt),
        .push_ok   (push_ok),
        .pop       (pop)
    );

    assign WDATA = head_e.data;
    assign WDST  = head_e.dst;
    assign WSIZE = head_e.size;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FLAGS    <= '0;
            FLAGS_WE <= 1'b0;
            STALL    <= 1'b0;
            OFLOW    <= 1'b0;
        end else begin
            FLAGS_WE <= pop;
            if (pop) begin
                FLAGS <= head_e.flags;
            end
            // Leaves SKID free slots for ops already past issue
            STALL <= (count_nxt >= CW'(DEPTH - SKID));
            if (RDY && !push_ok) begin
                OFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_result_writeback.sv
// Scoreboard bench for shift_result_writeback: directed pushes feed an
// expected queue, a negedge monitor checks every retiring entry and flag update.
module tb_shift_result_writeback;
    import shift_wb_pkg::*;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b0;
    logic        RDY   = 1'b0;
    logic [63:0] R     = '0;
    logic [3:0]  DST   = '0;
    logic [1:0]  SR    = '0;
    logic        OVR   = 1'b0;
    logic        ZERO  = 1'b0;
    logic        COUT  = 1'b0;
    logic        SIGN  = 1'b0;
    logic        GNT   = 1'b0;
    logic        STALL;
    logic        WE;
    logic [63:0] WDATA;
    logic [3:0]  WDST;
    logic [1:0]  WSIZE;
    logic [3:0]  FLAGS;
    logic        FLAGS_WE;
    logic [3:0]  COUNT;
    logic        OFLOW;

    shift_result_writeback #(
        .DSTWidth (4),
        .DEPTH    (8),
        .SKID     (3)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RDY      (RDY),
        .R        (R),
        .DST      (DST),
        .SR       (SR),
        .OVR      (OVR),
        .ZERO     (ZERO),
        .COUT     (COUT),
        .SIGN     (SIGN),
        .STALL    (STALL),
        .WE       (WE),
        .GNT      (GNT),
        .WDATA    (WDATA),
        .WDST     (WDST),
        .WSIZE    (WSIZE),
        .FLAGS    (FLAGS),
        .FLAGS_WE (FLAGS_WE),
        .COUNT    (COUNT),
        .OFLOW    (OFLOW)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    wb_entry_t  sb[$];
    wb_entry_t  mon_e;
    logic [3:0] exp_flags;
    bit         flag_pend = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push1(logic [63:0] r, logic [3:0] d, logic [1:0] s,
                         logic [3:0] f, bit ok);
        wb_entry_t e;
        R   = r;
        DST = d;
        SR  = s;
        {SIGN, ZERO, OVR, COUT} = f;
        RDY = 1'b1;
        if (ok) begin
            e.data  = r;
            e.dst   = d;
            e.size  = s;
            e.flags = f;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        RDY = 1'b0;
    endtask

    task automatic drain(int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(posedge CLK);
            n++;
        end
        chk("drain_left", 64'(sb.size()), 0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            flag_pend = 1'b0;
        end else begin
            if (flag_pend) begin
                chk("flags", FLAGS, exp_flags);
                chk("flags_we", FLAGS_WE, 1);
            end else begin
                chk("flags_we_idle", FLAGS_WE, 0);
            end
            flag_pend = 1'b0;
            if (WE && GNT) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: WDATA=%0h, none expected", WDATA);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wdata", WDATA, mon_e.data);
                    chk("wdst", WDST, mon_e.dst);
                    chk("wsize", WSIZE, mon_e.size);
                    exp_flags = mon_e.flags;
                    flag_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 RESET = 1'b1;
        #2;
        chk("rst_we", WE, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_stall", STALL, 0);
        chk("rst_oflow", OFLOW, 0);
        chk("rst_flags", {FLAGS, FLAGS_WE}, 0);
        chk("rst_wdata", WDATA, 0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;

        // single push with immediate grant
        GNT = 1'b1;
        push1(64'h0123_4567_89AB_CDEF, 4'd5, SZ_64, 4'b0000, 1);
        chk("s1_we", WE, 1);
        chk("s1_wdata", WDATA, 64'h0123_4567_89AB_CDEF);
        chk("s1_wdst", WDST, 5);
        chk("s1_count", COUNT, 1);
        @(posedge CLK); #1;
        chk("s1_count0", COUNT, 0);
        chk("s1_we0", WE, 0);
        chk("s1_flags_we", FLAGS_WE, 1);
        chk("s1_flags", FLAGS, 4'b0000);
        drain(4);

        // streaming with grant every cycle
        GNT = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            push1(64'(i), 4'(i), SZ_32, 4'(i), 1);
            chk("s3_count", COUNT, 1);
            chk("s3_wdata", WDATA, 64'(i));
            chk("s3_stall", STALL, 0);
        end
        drain(10);
        chk("s3_oflow", OFLOW, 0);
        chk("s3_count0", COUNT, 0);

        // fill without grant, overflow, then push+pop at full
        GNT = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push1(64'hA000 + 64'(i), 4'(i), SZ_16, 4'(i + 3), 1);
            chk("s2_count", COUNT, 64'(i + 1));
            chk("s2_stall", STALL, (i + 1 >= 5) ? 64'd1 : 64'd0);
            chk("s2_we", WE, 1);
            chk("s2_head", WDATA, 64'hA000);
        end
        push1(64'hDEAD, 4'hF, SZ_8, 4'b1111, 0);
        chk("s4_oflow", OFLOW, 1);
        chk("s4_count", COUNT, 8);
        chk("s4_head", WDATA, 64'hA000);
        GNT = 1'b1;
        push1(64'hBEEF, 4'd9, SZ_8, 4'b1100, 1);
        chk("s4_count_full", COUNT, 8);
        chk("s4_head_next", WDATA, 64'hA001);
        drain(20);
        chk("s5_flags", FLAGS, 4'b1100);
        chk("s4_oflow_sticky", OFLOW, 1);
        chk("s4_count0", COUNT, 0);
        chk("s4_stall0", STALL, 0);

        // reset in the middle of a drain
        GNT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push1(64'hC000 + 64'(i), 4'(i), SZ_64, 4'b0101, 1);
        end
        GNT = 1'b1;
        @(posedge CLK); #1;
        chk("s6_count3", COUNT, 3);
        #2 RESET = 1'b1;
        #1;
        chk("s6_we", WE, 0);
        chk("s6_count", COUNT, 0);
        chk("s6_stall", STALL, 0);
        chk("s6_oflow", OFLOW, 0);
        chk("s6_flags", FLAGS, 0);
        sb.delete();
        @(posedge CLK); #1;
        RESET = 1'b0;

        GNT = 1'b1;
        push1(64'h0123_4567_89AB_CDEF, 4'd5, SZ_64, 4'b0011, 1);
        chk("s6_we1", WE, 1);
        chk("s6_wdata", WDATA, 64'h0123_4567_89AB_CDEF);
        chk("s6_count1", COUNT, 1);
        @(posedge CLK); #1;
        chk("s6_count0", COUNT, 0);
        chk("s6_flags_new", FLAGS, 4'b0011);
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
